// File: rtl/axi_lite_master_bridge.sv
// rtl/axi_lite_master_bridge.sv - single-outstanding core req/gnt to AXI4-Lite master bridge
//
// Purpose: accepts one core request at a time on a req/gnt/rvalid port and
// issues the matching AXI4-Lite write (AW+W, then B) or read (AR, then R).
// Completion returns read data (0 after a write) and an error flag raised
// on SLVERR/DECERR or on a response ID that differs from AXI_ID.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   req_i       core request valid
//   we_i        1 = write, 0 = read
//   addr_i      byte address
//   wdata_i     write data
//   be_i        byte enables (write strobe)
//   gnt_o       request accepted this cycle (only in IDLE)
//   rvalid_o    one-cycle completion pulse
//   rdata_o     read data, held until the next completion
//   err_o       completion error flag, held with rdata_o
//   axi_req_o   AXI master request struct
//   axi_resp_i  AXI master response struct

`timescale 1ns/1ps

package axi_lite_master_bridge_pkg;

    typedef struct packed {
        logic [9:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } w_chan_t;

    typedef struct packed {
        logic [9:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [9:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } ar_chan_t;

    typedef struct packed {
        logic [9:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } lite_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } lite_resp_t;

endpackage

module axi_lite_master_bridge #(
    parameter int unsigned              AXI_ADDR_WIDTH = 64,
    parameter int unsigned              AXI_DATA_WIDTH = 64,
    parameter int unsigned              AXI_ID_WIDTH   = 10,
    parameter logic [AXI_ID_WIDTH-1:0]  AXI_ID         = '0,
    parameter type lite_req_t  = axi_lite_master_bridge_pkg::lite_req_t,
    parameter type lite_resp_t = axi_lite_master_bridge_pkg::lite_resp_t
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    output lite_req_t                   axi_req_o,
    input  lite_resp_t                  axi_resp_i
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R} state_e;

    state_e                        state_q;
    logic [AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0]   be_q;
    logic                          we_q;
    logic                          aw_done_q, w_done_q;
    logic                          aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;
    logic                          rvalid_q, err_q;
    logic [AXI_DATA_WIDTH-1:0]     rdata_q;

    logic aw_hs, w_hs, aw_done_next, w_done_next, b_err, r_err;

    assign aw_hs        = aw_valid_q & axi_resp_i.aw_ready;
    assign w_hs         = w_valid_q & axi_resp_i.w_ready;
    assign aw_done_next = aw_done_q | aw_hs;
    assign w_done_next  = w_done_q | w_hs;
    assign b_err        = axi_resp_i.b.resp[1] | (axi_resp_i.b.id != AXI_ID);
    assign r_err        = axi_resp_i.r.resp[1] | (axi_resp_i.r.id != AXI_ID);

    // The only combinational core-to-core path; AXI valids are all registered.
    assign gnt_o    = req_i & (state_q == IDLE) & ~rst_i;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        be_q    <= be_i;
                        we_q    <= we_i;
                        if (we_i) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            state_q    <= WR;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= RD_AR;
                        end
                    end
                end
                WR: begin
                    if (aw_hs) aw_valid_q <= 1'b0;
                    if (w_hs)  w_valid_q  <= 1'b0;
                    // Leaving on the cycle the last of AW/W completes, even if both complete together.
                    if (aw_done_next && w_done_next) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        b_ready_q <= 1'b1;
                        state_q   <= WR_B;
                    end else begin
                        aw_done_q <= aw_done_next;
                        w_done_q  <= w_done_next;
                    end
                end
                WR_B: begin
                    if (axi_resp_i.b_valid) begin
                        b_ready_q <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= b_err;
                        rvalid_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                RD_AR: begin
                    if (axi_resp_i.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= RD_R;
                    end
                end
                RD_R: begin
                    if (axi_resp_i.r_valid) begin
                        r_ready_q <= 1'b0;
                        rdata_q   <= axi_resp_i.r.data;
                        err_q     <= r_err;
                        rvalid_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = AXI_ID;
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.size  = AXI_SIZE;
        axi_req_o.aw.burst = 2'b01;
        axi_req_o.aw_valid = aw_valid_q;
        axi_req_o.w.data   = wdata_q;
        axi_req_o.w.strb   = be_q;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = w_valid_q;
        axi_req_o.b_ready  = b_ready_q;
        axi_req_o.ar.id    = AXI_ID;
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.size  = AXI_SIZE;
        axi_req_o.ar.burst = 2'b01;
        axi_req_o.ar_valid = ar_valid_q;
        axi_req_o.r_ready  = r_ready_q;
    end

    // Response fields this bridge deliberately ignores.
    logic unused_resp_bits;
    assign unused_resp_bits = ^{axi_resp_i.r.last, axi_resp_i.r.user, axi_resp_i.b.user,
                                axi_resp_i.b.resp[0], axi_resp_i.r.resp[0]};

    a_aw_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (axi_req_o.aw_valid && !axi_resp_i.aw_ready) |=> (axi_req_o.aw_valid && $stable(axi_req_o.aw)));
    a_w_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (axi_req_o.w_valid && !axi_resp_i.w_ready) |=> (axi_req_o.w_valid && $stable(axi_req_o.w)));
    a_ar_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (axi_req_o.ar_valid && !axi_resp_i.ar_ready) |=> (axi_req_o.ar_valid && $stable(axi_req_o.ar)));
    a_gnt_idle: assert property (@(posedge clk_i) gnt_o |-> (state_q == IDLE));
    a_wr_is_write: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == WR || state_q == WR_B) |-> we_q);

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb/tb_axi_lite_master_bridge.sv - self-checking bench for axi_lite_master_bridge
`timescale 1ns/1ps

module tb_axi_lite_master_bridge;
    import axi_lite_master_bridge_pkg::*;

    localparam logic [9:0] TB_ID = 10'h02A;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [63:0] addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic [7:0]  be_i = '0;
    logic        gnt_o, rvalid_o, err_o;
    logic [63:0] rdata_o;
    lite_req_t   axi_req;
    lite_resp_t  axi_resp = '0;

    axi_lite_master_bridge #(.AXI_ID(TB_ID)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .axi_req_o(axi_req), .axi_resp_i(axi_resp)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave behaviour knobs.
    int          aw_stall = 0, w_stall = 0, b_stall = 0, ar_stall = 0, r_stall = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [9:0]  b_id_cfg = TB_ID, r_id_cfg = TB_ID;
    logic [63:0] r_data_cfg = '0;

    // Monitor state, updated on the active edge.
    logic        aw_seen = 0, w_seen = 0, ar_seen = 0;
    logic [63:0] mon_aw_addr = '0, mon_w_data = '0, mon_ar_addr = '0;
    logic [7:0]  mon_w_strb = '0;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int          c_aw = 0, c_w = 0, c_ar = 0;
    int          proto_bad = 0;
    lite_req_t   prev_req = '0;
    logic        prev_aw_wait = 0, prev_w_wait = 0, prev_ar_wait = 0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            aw_seen <= 0; w_seen <= 0; ar_seen <= 0;
            prev_aw_wait <= 0; prev_w_wait <= 0; prev_ar_wait <= 0;
        end else begin
            if (prev_aw_wait && (!axi_req.aw_valid || axi_req.aw !== prev_req.aw)) proto_bad <= proto_bad + 1;
            if (prev_w_wait && (!axi_req.w_valid || axi_req.w !== prev_req.w)) proto_bad <= proto_bad + 1;
            if (prev_ar_wait && (!axi_req.ar_valid || axi_req.ar !== prev_req.ar)) proto_bad <= proto_bad + 1;
            if (axi_req.b_ready && !(aw_seen && w_seen)) proto_bad <= proto_bad + 1;
            if ((axi_req.aw_valid && aw_seen) || (axi_req.w_valid && w_seen)) proto_bad <= proto_bad + 1;
            if ((axi_req.ar_valid || axi_req.r_ready) &&
                (axi_req.aw_valid || axi_req.w_valid || axi_req.b_ready || aw_seen || w_seen))
                proto_bad <= proto_bad + 1;
            if (gnt_o && (axi_req.aw_valid || axi_req.w_valid || axi_req.b_ready ||
                          axi_req.ar_valid || axi_req.r_ready))
                proto_bad <= proto_bad + 1;
            if (axi_req.aw_valid && (axi_req.aw.id !== TB_ID || axi_req.aw.len !== 8'd0 ||
                axi_req.aw.size !== 3'd3 || axi_req.aw.burst !== 2'b01 || axi_req.aw.lock !== 1'b0 ||
                axi_req.aw.cache !== 4'd0 || axi_req.aw.prot !== 3'd0 || axi_req.aw.qos !== 4'd0 ||
                axi_req.aw.region !== 4'd0 || axi_req.aw.atop !== 6'd0 || axi_req.aw.user !== 1'b0))
                proto_bad <= proto_bad + 1;
            if (axi_req.w_valid && (axi_req.w.last !== 1'b1 || axi_req.w.user !== 1'b0))
                proto_bad <= proto_bad + 1;
            if (axi_req.ar_valid && (axi_req.ar.id !== TB_ID || axi_req.ar.len !== 8'd0 ||
                axi_req.ar.size !== 3'd3 || axi_req.ar.burst !== 2'b01 || axi_req.ar.lock !== 1'b0 ||
                axi_req.ar.cache !== 4'd0 || axi_req.ar.prot !== 3'd0 || axi_req.ar.qos !== 4'd0 ||
                axi_req.ar.region !== 4'd0 || axi_req.ar.user !== 1'b0))
                proto_bad <= proto_bad + 1;

            if (axi_req.aw_valid) c_aw <= c_aw + 1;
            if (axi_req.w_valid)  c_w  <= c_w + 1;
            if (axi_req.ar_valid) c_ar <= c_ar + 1;

            if (axi_req.aw_valid && axi_resp.aw_ready) begin
                aw_seen <= 1; n_aw <= n_aw + 1; mon_aw_addr <= axi_req.aw.addr;
            end
            if (axi_req.w_valid && axi_resp.w_ready) begin
                w_seen <= 1; n_w <= n_w + 1; mon_w_data <= axi_req.w.data; mon_w_strb <= axi_req.w.strb;
            end
            if (axi_resp.b_valid && axi_req.b_ready) begin
                aw_seen <= 0; w_seen <= 0; n_b <= n_b + 1;
            end
            if (axi_req.ar_valid && axi_resp.ar_ready) begin
                ar_seen <= 1; n_ar <= n_ar + 1; mon_ar_addr <= axi_req.ar.addr;
            end
            if (axi_resp.r_valid && axi_req.r_ready) begin
                ar_seen <= 0; n_r <= n_r + 1;
            end
            prev_req     <= axi_req;
            prev_aw_wait <= axi_req.aw_valid && !axi_resp.aw_ready;
            prev_w_wait  <= axi_req.w_valid && !axi_resp.w_ready;
            prev_ar_wait <= axi_req.ar_valid && !axi_resp.ar_ready;
        end
    end

    // Slave: readies after a programmable number of valid cycles, responses after a delay.
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            axi_resp <= '0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
        end else begin
            if (axi_req.aw_valid) begin axi_resp.aw_ready <= (aw_cnt >= aw_stall); aw_cnt <= aw_cnt + 1; end
            else begin axi_resp.aw_ready <= 0; aw_cnt <= 0; end
            if (axi_req.w_valid) begin axi_resp.w_ready <= (w_cnt >= w_stall); w_cnt <= w_cnt + 1; end
            else begin axi_resp.w_ready <= 0; w_cnt <= 0; end
            if (axi_req.ar_valid) begin axi_resp.ar_ready <= (ar_cnt >= ar_stall); ar_cnt <= ar_cnt + 1; end
            else begin axi_resp.ar_ready <= 0; ar_cnt <= 0; end
            if (aw_seen && w_seen) begin
                if (b_cnt >= b_stall) begin
                    axi_resp.b_valid <= 1; axi_resp.b.id <= b_id_cfg;
                    axi_resp.b.resp <= b_resp_cfg; axi_resp.b.user <= 1'($urandom);
                end else b_cnt <= b_cnt + 1;
            end else begin axi_resp.b_valid <= 0; b_cnt <= 0; end
            if (ar_seen) begin
                if (r_cnt >= r_stall) begin
                    axi_resp.r_valid <= 1; axi_resp.r.id <= r_id_cfg; axi_resp.r.data <= r_data_cfg;
                    axi_resp.r.resp <= r_resp_cfg; axi_resp.r.last <= 1'($urandom);
                    axi_resp.r.user <= 1'($urandom);
                end else r_cnt <= r_cnt + 1;
            end else begin axi_resp.r_valid <= 0; r_cnt <= 0; end
        end
    end

    task automatic set_slave(input int aws, ws, bs, ars, rs, input logic [1:0] bresp, rresp,
                             input logic [9:0] bid, rid, input logic [63:0] rdata);
        aw_stall = aws; w_stall = ws; b_stall = bs; ar_stall = ars; r_stall = rs;
        b_resp_cfg = bresp; r_resp_cfg = rresp; b_id_cfg = bid; r_id_cfg = rid; r_data_cfg = rdata;
    endtask

    // One request through to completion; expectations come from the slave knobs.
    task automatic run_txn(input string tag, input logic we, input logic [63:0] addr, wdata,
                           input logic [7:0] be);
        int g, lat, m, exp_lat, aw0, w0, b0, ar0, r0, caw0, cw0, car0;
        logic [63:0] exp_rdata;
        logic        exp_err;
        m = (aw_stall > w_stall) ? aw_stall : w_stall;
        exp_lat   = we ? (3 + m + b_stall) : (3 + ar_stall + r_stall);
        exp_rdata = we ? 64'd0 : r_data_cfg;
        exp_err   = we ? (b_resp_cfg[1] | (b_id_cfg != TB_ID)) : (r_resp_cfg[1] | (r_id_cfg != TB_ID));
        @(negedge clk_i);
        req_i = 1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
        #1;
        g = 0;
        while (!gnt_o && g < 50) begin @(negedge clk_i); #1; g++; end
        check({tag, "_gnt"}, 64'(gnt_o), 64'd1);
        aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r; caw0 = c_aw; cw0 = c_w; car0 = c_ar;
        lat = 0;
        while (lat < 80) begin
            @(negedge clk_i);
            lat++;
            if (rvalid_o) break;
            if (lat == 1) req_i = 0;
        end
        req_i = 0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_rdata"}, rdata_o, exp_rdata);
        check({tag, "_err"}, 64'(err_o), 64'(exp_err));
        if (we) begin
            check({tag, "_aw_addr"}, mon_aw_addr, addr);
            check({tag, "_w_data"}, mon_w_data, wdata);
            check({tag, "_w_strb"}, 64'(mon_w_strb), 64'(be));
            check({tag, "_hs_counts"}, 64'({n_aw - aw0, n_w - w0, n_b - b0, n_ar - ar0}),
                  64'({32'd1, 32'd1, 32'd1, 32'd0}) & 64'hFFFF_FFFF_FFFF_FFFF);
            check({tag, "_aw_valid_cycles"}, 64'(c_aw - caw0), 64'(aw_stall + 1));
            check({tag, "_w_valid_cycles"}, 64'(c_w - cw0), 64'(w_stall + 1));
        end else begin
            check({tag, "_ar_addr"}, mon_ar_addr, addr);
            check({tag, "_hs_counts"}, 64'({n_ar - ar0, n_r - r0, n_aw - aw0}), 64'({32'd1, 32'd1, 32'd0}));
            check({tag, "_ar_valid_cycles"}, 64'(c_ar - car0), 64'(ar_stall + 1));
        end
        @(negedge clk_i);
        check({tag, "_rvalid_width"}, 64'(rvalid_o), 64'd0);
        check({tag, "_rdata_hold"}, rdata_o, exp_rdata);
        check({tag, "_protocol"}, 64'(proto_bad), 64'd0);
    endtask

    initial begin
        logic [63:0] q_addr [4];
        logic [63:0] q_data [4];
        logic        q_we   [4];
        int          ng, nc, cyc, last_g, k;
        logic        adv, seen_rvalid;

        // Reset state.
        repeat (3) @(negedge clk_i);
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_rdata", rdata_o, 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_axi_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready,
                                     axi_req.ar_valid, axi_req.r_ready}), 64'd0);
        rst_i = 0;

        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, TB_ID, TB_ID, 64'd0);
        run_txn("wr_zero_wait", 1, 64'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF);

        set_slave(0, 0, 0, 3, 0, 2'b00, 2'b00, TB_ID, TB_ID, 64'h0123456789ABCDEF);
        run_txn("rd_ar_stall", 0, 64'h2000, 64'd0, 8'h00);

        set_slave(2, 0, 0, 0, 0, 2'b00, 2'b00, TB_ID, TB_ID, 64'd0);
        run_txn("wr_w_first", 1, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
        set_slave(0, 2, 1, 0, 0, 2'b00, 2'b00, TB_ID, TB_ID, 64'd0);
        run_txn("wr_aw_first", 1, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
        set_slave(1, 1, 0, 0, 0, 2'b00, 2'b00, TB_ID, TB_ID, 64'd0);
        run_txn("wr_same_cycle", 1, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));

        set_slave(0, 0, 0, 0, 1, 2'b00, 2'b10, TB_ID, TB_ID, {$urandom, $urandom});
        run_txn("rd_slverr", 0, {$urandom, $urandom}, 64'd0, 8'h00);
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, TB_ID + 10'd1, TB_ID, 64'd0);
        run_txn("wr_bad_bid", 1, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));

        for (int i = 0; i < 10; i++) begin
            set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), 2'($urandom),
                      ($urandom_range(0, 3) == 0) ? TB_ID + 10'd1 : TB_ID,
                      ($urandom_range(0, 3) == 0) ? TB_ID ^ 10'h100 : TB_ID, {$urandom, $urandom});
            run_txn("rand", 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
        end

        // Back-to-back with req_i held high, alternating write/read.
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, TB_ID, TB_ID, {$urandom, $urandom});
        for (int i = 0; i < 4; i++) begin
            q_we[i] = (i % 2 == 0); q_addr[i] = {$urandom, $urandom}; q_data[i] = {$urandom, $urandom};
        end
        @(negedge clk_i);
        req_i = 1; we_i = q_we[0]; addr_i = q_addr[0]; wdata_i = q_data[0]; be_i = 8'hFF;
        ng = 0; nc = 0; cyc = 0; last_g = 0; adv = 0;
        while (nc < 4 && cyc < 100) begin
            #1;
            if (rvalid_o) begin
                check("b2b_rdata", rdata_o, q_we[nc] ? 64'd0 : r_data_cfg);
                check("b2b_err", 64'(err_o), 64'd0);
                nc++;
            end
            if (gnt_o) begin
                if (ng > 0) begin
                    check("b2b_gnt_with_rvalid", 64'(rvalid_o), 64'd1);
                    check("b2b_gnt_gap", 64'(cyc - last_g), 64'd3);
                end
                last_g = cyc; ng++; adv = 1;
            end
            @(negedge clk_i);
            cyc++;
            if (adv) begin
                adv = 0;
                if (ng < 4) begin we_i = q_we[ng]; addr_i = q_addr[ng]; wdata_i = q_data[ng]; end
                else req_i = 0;
            end
        end
        req_i = 0;
        check("b2b_completions", 64'(nc), 64'd4);
        check("b2b_grants", 64'(ng), 64'd4);
        check("b2b_protocol", 64'(proto_bad), 64'd0);

        // Reset while waiting in WR_B.
        set_slave(0, 0, 20, 0, 0, 2'b00, 2'b00, TB_ID, TB_ID, 64'd0);
        @(negedge clk_i);
        req_i = 1; we_i = 1; addr_i = 64'h3000; wdata_i = {$urandom, $urandom}; be_i = 8'h0F;
        @(negedge clk_i);
        req_i = 0;
        k = 0;
        while (!axi_req.b_ready && k < 20) begin @(negedge clk_i); k++; end
        check("rst_mid_reached_wr_b", 64'(axi_req.b_ready), 64'd1);
        rst_i = 1;
        @(negedge clk_i);
        check("rst_mid_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready,
                                     axi_req.ar_valid, axi_req.r_ready}), 64'd0);
        check("rst_mid_rvalid", 64'(rvalid_o), 64'd0);
        @(negedge clk_i);
        rst_i = 0;
        seen_rvalid = 0;
        repeat (6) begin @(negedge clk_i); if (rvalid_o) seen_rvalid = 1; end
        check("rst_mid_no_completion", 64'(seen_rvalid), 64'd0);
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, TB_ID, TB_ID, {$urandom, $urandom});
        run_txn("rd_after_reset", 0, {$urandom, $urandom}, 64'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
